// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch resolution controller.
// Used by branch_bht and branch_ctrl.
package branch_ctrl_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bc_state_e;

    localparam logic [1:0] BHT_INIT_DEF = 2'b01;
    localparam logic [1:0] CTR_MAX      = 2'b11;
    localparam logic [1:0] CTR_MIN      = 2'b00;

    // Saturating 2-bit predictor counter step.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (IF) and one registered write port (EX).
module branch_bht
    import branch_ctrl_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] BHT_INIT  = BHT_INIT_DEF,
    localparam int        IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    logic [1:0] ctr_q [BHT_DEPTH];
    logic [1:0] wr_ctr_d;

    // Read returns the stored value; a same-cycle write is not bypassed.
    assign rd_taken_o = ctr_q[rd_idx_i][1];
    assign wr_ctr_d   = ctr_update(ctr_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: taken decision, mispredict detection, registered
// redirect/flush sequencing and BHT ownership. Optional stats: BRANCH_CTRL_STATS_EN.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] BHT_INIT  = BHT_INIT_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            br_less,
    input  logic            br_equal,
    output logic            br_unsigned,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_ex
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bc_state_e       state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_if_id_q, flush_if_id_d;
    logic            flush_ex_q, flush_ex_d;

    logic            is_jump;
    logic            resolve;
    logic            cond_taken;
    logic            cond_known;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] fallthrough_pc;
    logic            bht_we;
    logic            unused_if_pc;

    assign br_unsigned = ex_funct3[1];
    assign is_jump     = ex_is_jal | ex_is_jalr;
    assign resolve     = ex_valid & ~ex_stall & (state_q == RUN)
                       & (ex_is_branch | is_jump);

    always_comb begin
        cond_taken = 1'b0;
        cond_known = 1'b1;
        case (br_funct3_e'(ex_funct3))
            BEQ:       cond_taken = br_equal;
            BNE:       cond_taken = ~br_equal;
            BLT, BLTU: cond_taken = br_less;
            BGE, BGEU: cond_taken = ~br_less;
            default:   cond_known = 1'b0;
        endcase
    end

    // Jumps have no BTB behind them, so the fetch path never followed them.
    assign taken          = is_jump | cond_taken;
    assign mispredict     = resolve & (is_jump | (taken != ex_pred_taken));
    assign jump_target    = ex_is_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
    assign fallthrough_pc = ex_pc + XLEN'(4);

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_if_id_d    = 1'b0;
        flush_ex_d       = 1'b0;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = taken ? jump_target : fallthrough_pc;
                    flush_if_id_d    = 1'b1;
                    flush_ex_d       = 1'b1;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_if_id_q    <= 1'b0;
            flush_ex_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_if_id_q    <= flush_if_id_d;
            flush_ex_q       <= flush_ex_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_if_id_q;
    assign flush_ex       = flush_ex_q;

    // Only resolved conditional branches with a real compare train the table.
    assign bht_we = resolve & ex_is_branch & ~is_jump & cond_known;

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .BHT_INIT  (BHT_INIT)
    ) u_bht (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .rd_idx_i   (if_pc[IDX_W+1:2]),
        .rd_taken_o (if_pred_taken),
        .wr_en_i    (bht_we),
        .wr_idx_i   (ex_pc[IDX_W+1:2]),
        .wr_taken_i (cond_taken)
    );

    assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (resolve && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: registered outputs go through an expected
// queue, combinational outputs are checked in place.
module tb_branch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken, br_less, br_equal;
    logic        br_unsigned, redirect_valid, flush_if_id, flush_ex;
    logic [31:0] redirect_pc;
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [34:0] exp_q[$];
    logic [31:0] rpc_hold;

    always #5 i_clk = ~i_clk;

    branch_ctrl dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .br_less        (br_less),
        .br_equal       (br_equal),
        .br_unsigned    (br_unsigned),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_ex       (flush_ex)
`ifdef BRANCH_CTRL_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 3'b000; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 0; br_less = 0; br_equal = 0;
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic less, input logic eq);
        ex_valid = 1; ex_stall = 0; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; br_less = less; br_equal = eq;
    endtask

    // One clock: expected {redirect_valid, flush_if_id, flush_ex, redirect_pc} after the edge.
    task automatic tick(input string tag, input logic redir, input logic [31:0] pc);
        logic [34:0] got;
        logic [34:0] want;
        if (redir) rpc_hold = pc;
        exp_q.push_back({redir, redir, redir, rpc_hold});
        @(posedge i_clk);
        #1;
        got  = {redirect_valid, flush_if_id, flush_ex, redirect_pc};
        want = exp_q.pop_front();
        check(tag, 64'(got), 64'(want));
    endtask

    task automatic do_reset();
        i_rst_n  = 0;
        idle();
        rpc_hold = '0;
        tick("reset_outputs", 1'b0, 32'h0);
        i_rst_n  = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n  = 0;
        rpc_hold = '0;
        if_pc    = 32'h100;
        idle();
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();
        #1 check("rst_pred_0x100", 64'(if_pred_taken), 64'd0);
        check("rst_unsigned", 64'(br_unsigned), 64'd0);

        // BEQ taken, predicted not-taken: one-cycle redirect then quiet.
        drive(1, 0, 0, 3'b000, 32'h200, 32'h240, 0, 0, 1);
        tick("beq_redirect", 1, 32'h240);
        idle();
        tick("beq_flush_end", 0, 0);
        tick("beq_idle", 0, 0);
`ifdef BRANCH_CTRL_STATS_EN
        check("stat_branches_1", 64'(stat_branches), 64'd1);
        check("stat_mispredicts_1", 64'(stat_mispredicts), 64'd1);
`endif
        do_reset();

        // BLTU not-taken twice: counter 01 -> 00 -> 00, then two taken: 01, 10.
        if_pc = 32'h200;
        drive(1, 0, 0, 3'b110, 32'h200, 32'h280, 0, 0, 0);
        #1 check("bltu_unsigned", 64'(br_unsigned), 64'd1);
        tick("bltu_nt1", 0, 0);
        tick("bltu_nt2", 0, 0);
        drive(1, 0, 0, 3'b110, 32'h200, 32'h280, 1, 1, 0);
        #1 check("bltu_pred_pre", 64'(if_pred_taken), 64'd0);
        tick("bltu_t1", 0, 0);
        #1 check("bltu_ctr_01", 64'(if_pred_taken), 64'd0);
        tick("bltu_t2", 0, 0);
        #1 check("bltu_ctr_10", 64'(if_pred_taken), 64'd1);

        // Stalled mispredicting branch: no redirect, no counter change.
        drive(1, 0, 0, 3'b110, 32'h200, 32'h280, 1, 0, 0);
        ex_stall = 1;
        tick("stall_no_redirect", 0, 0);
        #1 check("stall_no_update", 64'(if_pred_taken), 64'd1);

        // funct3 010: never taken, table untouched.
        drive(1, 0, 0, 3'b010, 32'h200, 32'h280, 0, 1, 1);
        tick("f3_010_no_redirect", 0, 0);
        #1 check("f3_010_no_update", 64'(if_pred_taken), 64'd1);
        do_reset();
        #1 check("reset_bht_0x200", 64'(if_pred_taken), 64'd0);

        // BNE taken 4x saturates at 11, then two not-taken: 10, 01.
        if_pc = 32'h300;
        drive(1, 0, 0, 3'b001, 32'h300, 32'h340, 1, 0, 0);
        #1 check("bne_pred_pre", 64'(if_pred_taken), 64'd0);
        check("bne_signed", 64'(br_unsigned), 64'd0);
        tick("bne_t1", 0, 0);
        #1 check("bne_ctr_10", 64'(if_pred_taken), 64'd1);
        tick("bne_t2", 0, 0);
        #1 check("bne_ctr_11", 64'(if_pred_taken), 64'd1);
        tick("bne_t3", 0, 0);
        tick("bne_t4", 0, 0);
        drive(1, 0, 0, 3'b001, 32'h300, 32'h340, 0, 0, 1);
        tick("bne_nt1", 0, 0);
        #1 check("bne_ctr_sat_dec", 64'(if_pred_taken), 64'd1);
        tick("bne_nt2", 0, 0);
        #1 check("bne_ctr_01", 64'(if_pred_taken), 64'd0);
        do_reset();

        // Redirect address selection across funct3 kinds.
        drive(1, 0, 0, 3'b100, 32'h400, 32'h480, 0, 1, 0);
        tick("blt_taken", 1, 32'h480);
        idle();
        tick("blt_flush_end", 0, 0);
        drive(1, 0, 0, 3'b101, 32'h500, 32'h580, 1, 1, 0);
        tick("bge_fallthrough", 1, 32'h504);
        idle();
        tick("bge_flush_end", 0, 0);
        drive(1, 0, 0, 3'b111, 32'hFFFF_FFFC, 32'h10, 1, 1, 0);
        #1 check("bgeu_unsigned", 64'(br_unsigned), 64'd1);
        tick("bgeu_pc_wrap", 1, 32'h0);
        idle();
        tick("bgeu_flush_end", 0, 0);
        drive(0, 1, 0, 3'b000, 32'h600, 32'h700, 1, 0, 0);
        tick("jal_redirect", 1, 32'h700);
        idle();
        tick("jal_flush_end", 0, 0);

        // JALR clears bit 0; a mispredicting BEQ during FLUSH is ignored.
        if_pc = 32'h800;
        drive(0, 0, 1, 3'b000, 32'h800, 32'h1235, 1, 0, 0);
        tick("jalr_bit0", 1, 32'h1234);
        drive(1, 0, 0, 3'b000, 32'h800, 32'h840, 0, 0, 1);
        tick("flush_ignores_ex", 0, 0);
        #1 check("flush_no_bht_write", 64'(if_pred_taken), 64'd0);
        idle();
        tick("after_flush_idle", 0, 0);

        // Reset asserted during FLUSH drops the flush and restores the table.
        if_pc = 32'h200;
        drive(1, 0, 0, 3'b000, 32'h200, 32'h240, 0, 0, 1);
        tick("pre_rst_redirect", 1, 32'h240);
        #1 check("pre_rst_bht", 64'(if_pred_taken), 64'd1);
        do_reset();
        #1 check("rst_bht_init", 64'(if_pred_taken), 64'd0);
`ifdef BRANCH_CTRL_STATS_EN
        check("stat_branches_rst", 64'(stat_branches), 64'd0);
        check("stat_mispredicts_rst", 64'(stat_mispredicts), 64'd0);
`endif
        idle();
        tick("post_rst_idle", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
